ctrl_decode_stage: RTL and testbench
====================================

// Module: ctrl_decode_stage
// PURPOSE
//  Registered, parametrised successor to the combinational control decoder: decodes a 32-bit RV32I(+M) instruction
//  into the control bundle and holds it in a 2-entry skid buffer between IF/ID and EX, with valid/ready handshakes.
//  Adds illegal-instruction detection, optional M-extension decode, pipeline flush and no X on any output.
// PARAMETERS
//  EN_M        1'b0   1: decode RV32M (funct7=0000001 on opcode 0110011); 0: those encodings are illegal
//  ALU_CTRL_W  -      localparam = EN_M ? 5 : 4; width of aluCtrl
// PORTS
//  clk        in   1           clock, rising edge
//  rstN       in   1           asynchronous reset, active low
//  flush      in   1           drop every buffered entry and any input accepted this cycle
//  inValid    in   1           instr valid
//  inReady    out  1           stage can accept instr (registered; = state!=FULL2)
//  instr      in   32          raw instruction
//  outValid   out  1           head entry valid
//  outReady   in   1           EX consumes head entry
//  regWrt,memWrt,jmp,brnch,aluSrc  out 1 each   control bits, same meaning as the existing decoder
//  rsltSrc    out  2           00 ALU, 01 mem, 10 PC+4, 11 imm/upper
//  ujMux      out  2           00 LUI, 01 AUIPC/JAL, 10 JALR
//  immSrc     out  3           000 I, 001 S, 010 B, 011 J, 100 U
//  aluCtrl    out  ALU_CTRL_W  see ALU encoding below
//  rd,rs1,rs2 out  5 each      register fields of head entry
//  funct3     out  3           funct3 of head entry (branch condition for EX)
//  illegal    out  1           head entry is an illegal instruction
// BEHAVIOUR
//  - Reset (rstN=0, async): state=EMPTY, outValid=0, inReady=1, all bundle outputs 0.
//  - State machine: EMPTY -> ONE on push; ONE -> TWO on push without pop; ONE -> EMPTY on pop without push;
//    TWO -> ONE on pop. Push = inValid&inReady; pop = outValid&outReady; push+pop in ONE stays ONE.
//  - Latency: instr accepted in cycle N appears at the outputs in N+1 when the buffer was EMPTY or popped in N.
//    FIFO order is preserved.
//  - Outputs are driven from the head register only; inReady depends on state, never combinationally on outReady.
//  - flush=1: next state EMPTY and outValid=0 at next edge; a push in the same cycle is discarded; flush beats push/pop.
//  - Decode per opcode:
//    load: regWrt, aluSrc, immSrc 000, rsltSrc 01.  OP-IMM: regWrt, aluSrc, immSrc 000.
//    OP: regWrt.  store: memWrt, aluSrc, immSrc 001.  branch: brnch, immSrc 010.
//    LUI/AUIPC: regWrt, immSrc 100, rsltSrc 11, ujMux 00/01.
//    JAL: jmp, regWrt, immSrc 011, rsltSrc 10, ujMux 01.  JALR: jmp, regWrt, immSrc 000, rsltSrc 10, ujMux 10.
//  - ALU encoding (low 4 bits):
//    ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SLT 0111, SRA 1000, SLTU 1001.
//    Branch: BEQ/BNE 0001, BLT/BGE 0111, BLTU/BGEU 1001.
//    EN_M: MSB=1 with low 3 bits = funct3 (MUL..REMU); MSB=0 for all base ops.
//  - Don't-care fields are driven 0, never X.
//  - Illegal when any of:
//    opcode is not one of the nine above; OP funct7 is not in {0000000, 0100000, 0000001 if EN_M};
//    0100000 is used with funct3 other than 000/101; SLLI/SRLI/SRAI has a bad funct7;
//    branch funct3 is 010/011; load funct3 is 011/110/111; store funct3 >= 011; JALR funct3 != 000.
//    Illegal entry: illegal=1, regWrt=memWrt=jmp=brnch=0, rd/rs fields passed through.
//  - Illegal entries still occupy the buffer and obey the handshake.
// STRUCTURE
//  - ctrl_pkg: opcode localparams, aluCtrl constants, immSrc/rsltSrc/ujMux enums, ctrl_bundle_t packed struct,
//    buf_state_t {EMPTY, ONE, TWO}.
//  - Sub-module ctrl_decode_comb (instr, EN_M) -> ctrl_bundle_t: pure combinational; the stage wraps it
//    with two bundle registers and the FSM.
// TESTING
//  - EN_M=0, EMPTY, push 0x00500093 (addi x1,x0,5), outReady=1 -> next cycle outValid=1, regWrt=1, aluSrc=1,
//    aluCtrl=0000, rd=1, illegal=0.
//  - Push 0x402081B3 (sub x3,x1,x2) -> aluCtrl=0001, aluSrc=0, rd=3, rs1=1, rs2=2.
//    Then push 0x00208463 (beq) -> brnch=1, immSrc=010, aluCtrl=0001, regWrt=0.
//  - Push 0x022081B3 (mul): EN_M=1 -> aluCtrl=5'b10000, illegal=0; EN_M=0 -> illegal=1, regWrt=0.
//    Also push 0xFFFFFFFF -> illegal=1.
//  - outReady=0, push 3 back-to-back -> inReady=0 after the 2nd accept, 3rd held.
//    outReady=1 -> entries emerge in order 1,2,3, one per cycle.
//  - state TWO, flush=1 with inValid=1 -> next cycle outValid=0, inReady=1, pushed instr never appears.
//  - rstN low mid-stream (async, between edges) -> outValid=0, all outputs 0 immediately.
//    Release -> first new push appears after 1 cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I(+M) control decoder and its skid-buffered decode stage.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;

  typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_e;
  typedef enum logic [1:0] {RSLT_ALU = 2'b00, RSLT_MEM, RSLT_PC4, RSLT_IMM} rslt_src_e;
  typedef enum logic [1:0] {UJ_LUI = 2'b00, UJ_PC = 2'b01, UJ_JALR = 2'b10} uj_mux_e;

  typedef struct packed {
    logic       reg_wrt;
    logic       mem_wrt;
    logic       jmp;
    logic       brnch;
    logic       alu_src;
    rslt_src_e  rslt_src;
    uj_mux_e    uj_mux;
    imm_src_e   imm_src;
    logic [4:0] alu_ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10} buf_state_t;

  // Base-ISA ALU op for OP/OP-IMM; alt selects SUB/SRA (funct7 = 0100000).
  function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32I(+M) decoder: instruction word to control bundle, with illegal-encoding detection.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       illegal;
  logic       is_mul;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign is_mul = EN_M && (funct7 == F7_MULDIV);

  // NOTE: every field gets a default first so no path through the case can infer a latch.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_wrt  = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.rslt_src = RSLT_MEM;
        illegal       = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_IMM: begin
        ctrl.reg_wrt  = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = alu_base(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        if (funct3 == 3'b001) illegal = (funct7 != F7_BASE);
        if (funct3 == 3'b101) illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OP_REG: begin
        ctrl.reg_wrt  = 1'b1;
        ctrl.alu_ctrl = is_mul ? {2'b10, funct3} : alu_base(funct3, funct7 == F7_ALT);
        illegal = !((funct7 == F7_BASE) || is_mul ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_STORE: begin
        ctrl.mem_wrt = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.imm_src = IMM_S;
        illegal      = (funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        ctrl.brnch   = 1'b1;
        ctrl.imm_src = IMM_B;
        case (funct3[2:1])
          2'b00:   ctrl.alu_ctrl = ALU_SUB;
          2'b10:   ctrl.alu_ctrl = ALU_SLT;
          2'b11:   ctrl.alu_ctrl = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.reg_wrt  = 1'b1;
        ctrl.imm_src  = IMM_U;
        ctrl.rslt_src = RSLT_IMM;
        ctrl.uj_mux   = (opcode == OP_LUI) ? UJ_LUI : UJ_PC;
      end
      OP_JAL: begin
        ctrl.jmp      = 1'b1;
        ctrl.reg_wrt  = 1'b1;
        ctrl.imm_src  = IMM_J;
        ctrl.rslt_src = RSLT_PC4;
        ctrl.uj_mux   = UJ_PC;
      end
      OP_JALR: begin
        ctrl.jmp      = 1'b1;
        ctrl.reg_wrt  = 1'b1;
        ctrl.imm_src  = IMM_I;
        ctrl.rslt_src = RSLT_PC4;
        ctrl.uj_mux   = UJ_JALR;
        illegal       = (funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase

    // An illegal entry carries no side effects; only the raw fields survive.
    if (illegal) ctrl = '0;
    ctrl.rd      = instr[11:7];
    ctrl.rs1     = instr[19:15];
    ctrl.rs2     = instr[24:20];
    ctrl.funct3  = funct3;
    ctrl.illegal = illegal;
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: combinational decoder feeding a 2-entry skid buffer with valid/ready on both sides.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b0,
  localparam int ALU_CTRL_W = EN_M ? 5 : 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [31:0]           instr,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  regWrt,
  output logic                  memWrt,
  output logic                  jmp,
  output logic                  brnch,
  output logic                  aluSrc,
  output logic [1:0]            rsltSrc,
  output logic [1:0]            ujMux,
  output logic [2:0]            immSrc,
  output logic [ALU_CTRL_W-1:0] aluCtrl,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [2:0]            funct3,
  output logic                  illegal
);

  buf_state_t   state, state_nxt;
  ctrl_bundle_t dec, head_q, tail_q, head_d, tail_d;
  logic         push, pop;
  logic         unused_alu_msb;

  ctrl_decode_comb #(.EN_M(EN_M)) u_decode (
    .instr (instr),
    .ctrl  (dec)
  );

  // Both handshake outputs come straight from the state register.
  assign outValid = (state != EMPTY);
  assign inReady  = (state != TWO);
  assign push     = inValid & inReady;
  assign pop      = outValid & outReady;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush) begin
      state_nxt = EMPTY;
      head_d    = '0;
      tail_d    = '0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          head_d    = dec;
          state_nxt = ONE;
        end
        ONE: case ({push, pop})
          2'b10: begin
            tail_d    = dec;
            state_nxt = TWO;
          end
          2'b01:   state_nxt = EMPTY;
          2'b11:   head_d    = dec;
          default: ;
        endcase
        TWO: if (pop) begin
          head_d    = tail_q;
          state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: the two buffer entries are reset too, so no bundle output is ever X after reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign regWrt         = head_q.reg_wrt;
  assign memWrt         = head_q.mem_wrt;
  assign jmp            = head_q.jmp;
  assign brnch          = head_q.brnch;
  assign aluSrc         = head_q.alu_src;
  assign rsltSrc        = head_q.rslt_src;
  assign ujMux          = head_q.uj_mux;
  assign immSrc         = head_q.imm_src;
  assign aluCtrl        = head_q.alu_ctrl[ALU_CTRL_W-1:0];
  assign unused_alu_msb = head_q.alu_ctrl[4];
  assign rd             = head_q.rd;
  assign rs1            = head_q.rs1;
  assign rs2            = head_q.rs2;
  assign funct3         = head_q.funct3;
  assign illegal        = head_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench: drives an EN_M=0 and an EN_M=1 stage in lockstep against a queue-based reference model.
module tb_ctrl_decode_stage;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [31:0] instr;

  // Observation vector layout: [37] outValid [36] inReady [35:0] bundle
  // bundle = {regWrt,memWrt,jmp,brnch,aluSrc, rsltSrc[2], ujMux[2], immSrc[3], aluCtrl[5], rd, rs1, rs2, funct3, illegal}
  wire [37:0] obs0, obs1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] q[$];

  ctrl_decode_stage #(.EN_M(1'b0)) dut0 (
    .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(obs0[36]), .instr(instr),
    .outValid(obs0[37]), .outReady(outReady), .regWrt(obs0[35]), .memWrt(obs0[34]), .jmp(obs0[33]),
    .brnch(obs0[32]), .aluSrc(obs0[31]), .rsltSrc(obs0[30:29]), .ujMux(obs0[28:27]), .immSrc(obs0[26:24]),
    .aluCtrl(obs0[22:19]), .rd(obs0[18:14]), .rs1(obs0[13:9]), .rs2(obs0[8:4]), .funct3(obs0[3:1]),
    .illegal(obs0[0])
  );
  assign obs0[23] = 1'b0;

  ctrl_decode_stage #(.EN_M(1'b1)) dut1 (
    .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(obs1[36]), .instr(instr),
    .outValid(obs1[37]), .outReady(outReady), .regWrt(obs1[35]), .memWrt(obs1[34]), .jmp(obs1[33]),
    .brnch(obs1[32]), .aluSrc(obs1[31]), .rsltSrc(obs1[30:29]), .ujMux(obs1[28:27]), .immSrc(obs1[26:24]),
    .aluCtrl(obs1[23:19]), .rd(obs1[18:14]), .rs1(obs1[13:9]), .rs2(obs1[8:4]), .funct3(obs1[3:1]),
    .illegal(obs1[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode from the instruction-set rules, table-driven.
  function automatic logic [35:0] ref_decode(input logic [31:0] ins, input bit en_m);
    logic [4:0] alu_tbl [8];
    logic [6:0] op, f7;
    logic [2:0] f3, is;
    logic [4:0] ctl, alu;
    logic [1:0] rs, uj;
    bit         ill;
    alu_tbl = '{5'd0, 5'd5, 5'd7, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ctl = 5'b0; rs = 2'd0; uj = 2'd0; is = 3'd0; alu = 5'd0; ill = 1'b0;
    case (op)
      7'h03: begin ctl = 5'b10001; rs = 2'd1; ill = (f3 == 3) || (f3 >= 6); end
      7'h13: begin
        ctl = 5'b10001; alu = alu_tbl[f3];
        if (f3 == 5 && f7 == 7'h20) alu = 5'd8;
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !(f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin
        ctl = 5'b10000;
        if (f7 == 7'h01 && en_m)         alu = {2'b10, f3};
        else if (f7 == 0)                alu = alu_tbl[f3];
        else if (f7 == 7'h20 && f3 == 0) alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 5) alu = 5'd8;
        else                             ill = 1'b1;
      end
      7'h23: begin ctl = 5'b01001; is = 3'd1; ill = (f3 >= 3); end
      7'h63: begin
        ctl = 5'b00010; is = 3'd2;
        alu = (f3 < 2) ? 5'd1 : (f3 < 4) ? 5'd0 : (f3 < 6) ? 5'd7 : 5'd9;
        ill = (f3 == 2) || (f3 == 3);
      end
      7'h37: begin ctl = 5'b10000; is = 3'd4; rs = 2'd3; uj = 2'd0; end
      7'h17: begin ctl = 5'b10000; is = 3'd4; rs = 2'd3; uj = 2'd1; end
      7'h6F: begin ctl = 5'b10100; is = 3'd3; rs = 2'd2; uj = 2'd1; end
      7'h67: begin ctl = 5'b10100; is = 3'd0; rs = 2'd2; uj = 2'd2; ill = (f3 != 0); end
      default: ill = 1'b1;
    endcase
    if (ill) begin ctl = 5'b0; rs = 2'd0; uj = 2'd0; is = 3'd0; alu = 5'd0; end
    return {ctl, rs, uj, is, alu, ins[11:7], ins[19:15], ins[24:20], f3, ill};
  endfunction

  function automatic logic [37:0] exp_vec(input bit en_m);
    if (q.size() == 0) return {1'b0, 1'b1, 36'b0};
    return {1'b1, q.size() < 2, ref_decode(q[0], en_m)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [6:0] f7s [3];
    logic [31:0] ins;
    int k;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    f7s = '{7'h00, 7'h20, 7'h01};
    ins = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) ins[6:0] = ops[k];
    k = $urandom_range(0, 3);
    if (k < 3) ins[31:25] = f7s[k];
    return ins;
  endfunction

  // Drive one cycle from a negedge, advance the model, return at the next negedge.
  task automatic step(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl);
    bit do_push, do_pop;
    inValid = iv; instr = ins; outReady = ordy; flush = fl;
    do_push = iv && (q.size() < 2);
    do_pop  = (q.size() != 0) && ordy;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ins);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; instr = 32'h0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs0 !== {1'b0, 1'b1, 36'b0}) begin
      n_fail++; $display("FAIL reset_m0: got %h want %h", obs0, {1'b0, 1'b1, 36'b0});
    end
    n_cmp++;
    if (obs1 !== {1'b0, 1'b1, 36'b0}) begin
      n_fail++; $display("FAIL reset_m1: got %h want %h", obs1, {1'b0, 1'b1, 36'b0});
    end
    rstN = 1'b1;
  endtask

  task automatic test_addi();
    step(1'b1, 32'h00500093, 1'b1, 1'b0);
    n_cmp++;
    if ({obs0[37], obs0[35], obs0[31], obs0[23:19], obs0[18:14], obs0[0]} !== {1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 1'b0}) begin
      n_fail++; $display("FAIL addi_fields: got %h want %h", obs0, {1'b1, 1'b1, 36'h0});
    end
    n_cmp++;
    if (obs0 !== exp_vec(1'b0)) begin
      n_fail++; $display("FAIL addi_model: got %h want %h", obs0, exp_vec(1'b0));
    end
  endtask

  task automatic test_alu_branch();
    step(1'b1, 32'h402081B3, 1'b1, 1'b0);
    n_cmp++;
    if ({obs0[37], obs0[31], obs0[23:19], obs0[18:14], obs0[13:9], obs0[8:4]} !== {1'b1, 1'b0, 5'd1, 5'd3, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL sub_fields: got %h", obs0);
    end
    step(1'b1, 32'h00208463, 1'b1, 1'b0);
    n_cmp++;
    if ({obs0[37], obs0[32], obs0[26:24], obs0[23:19], obs0[35]} !== {1'b1, 1'b1, 3'b010, 5'd1, 1'b0}) begin
      n_fail++; $display("FAIL beq_fields: got %h", obs0);
    end
    n_cmp++;
    if (obs1 !== exp_vec(1'b1)) begin
      n_fail++; $display("FAIL beq_model_m1: got %h want %h", obs1, exp_vec(1'b1));
    end
  endtask

  task automatic test_mul_illegal();
    step(1'b1, 32'h022081B3, 1'b1, 1'b0);
    n_cmp++;
    if ({obs1[37], obs1[35], obs1[23:19], obs1[0]} !== {1'b1, 1'b1, 5'b10000, 1'b0}) begin
      n_fail++; $display("FAIL mul_en_m: got %h", obs1);
    end
    n_cmp++;
    if ({obs0[37], obs0[35], obs0[0], obs0[18:14]} !== {1'b1, 1'b0, 1'b1, 5'd3}) begin
      n_fail++; $display("FAIL mul_no_m: got %h", obs0);
    end
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    n_cmp++;
    if ({obs0[0], obs1[0], obs0[35:31], obs1[35:31]} !== {1'b1, 1'b1, 10'b0}) begin
      n_fail++; $display("FAIL all_ones: got %h / %h", obs0, obs1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq = '{32'h00100093, 32'h00200113, 32'h00300193};
    step(1'b1, seq[0], 1'b0, 1'b0);
    step(1'b1, seq[1], 1'b0, 1'b0);
    n_cmp++;
    if ({obs0[37], obs0[36], obs0[18:14]} !== {1'b1, 1'b0, 5'd1}) begin
      n_fail++; $display("FAIL b2b_full: got %h", obs0);
    end
    step(1'b1, seq[2], 1'b0, 1'b0);
    n_cmp++;
    if ({obs0[36], obs0[18:14]} !== {1'b0, 5'd1}) begin
      n_fail++; $display("FAIL b2b_held: got %h", obs0);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({obs0[37], obs0[18:14]} !== {1'b1, 5'(i + 1)}) begin
        n_fail++; $display("FAIL b2b_order%0d: got rd %0d want %0d", i, obs0[18:14], i + 1);
      end
      step(1'b1, seq[2], 1'b1, 1'b0);
      inValid = 1'b0;
      if (i == 1) begin
        step(1'b0, 32'h0, 1'b0, 1'b0);
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (obs0[37:36] !== 2'b01) begin
      n_fail++; $display("FAIL b2b_drain: got %b want 01", obs0[37:36]);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 1'b0, 1'b0);
    step(1'b1, 32'h00700393, 1'b1, 1'b1);
    n_cmp++;
    if ({obs0[37:36], obs1[37:36]} !== 4'b0101) begin
      n_fail++; $display("FAIL flush_state: got %b want 0101", {obs0[37:36], obs1[37:36]});
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (obs0[37] !== 1'b0) begin
      n_fail++; $display("FAIL flush_discard: outValid %b want 0", obs0[37]);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 1'b0, 1'b0);
    #2 rstN = 1'b0;
    #1;
    n_cmp++;
    if ({obs0, obs1} !== {1'b0, 1'b1, 36'b0, 1'b0, 1'b1, 36'b0}) begin
      n_fail++; $display("FAIL async_reset: got %h / %h", obs0, obs1);
    end
    q.delete();
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    step(1'b1, 32'h00A00293, 1'b1, 1'b0);
    n_cmp++;
    if ({obs0[37], obs0[18:14], obs0[0]} !== {1'b1, 5'd5, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_push: got %h", obs0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [37:0] e0, e1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      e0 = exp_vec(1'b0);
      e1 = exp_vec(1'b1);
      n_cmp++;
      if (e0[37] ? (obs0 !== e0) : (obs0[37:36] !== e0[37:36])) begin
        n_fail++; $display("FAIL rand_m0 cyc %0d: got %h want %h", i, obs0, e0);
      end
      n_cmp++;
      if (e1[37] ? (obs1 !== e1) : (obs1[37:36] !== e1[37:36])) begin
        n_fail++; $display("FAIL rand_m1 cyc %0d: got %h want %h", i, obs1, e1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu_branch();
    test_mul_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
